// File: rtl/freq_meter_mc.sv
// Purpose : multi-channel equal-precision frequency meter; counts sys_clk cycles across N whole periods of one selected input.
// Latency : input rise -> internal rise pulse 3 cycles; close rise -> done/results 2 cycles later; invalid channel -> done 2 cycles after start.
// Backpr. : none; start is ignored unless the FSM is idle; results and error flags hold until the next done pulse.
//
// Ports:
//   sys_clk, rst_n            reference clock (rising edge) and asynchronous active-low reset
//   sig_in[NUM_CH]            asynchronous test signals
//   start, ch_sel, gate_edges measurement request, channel and gate length (periods, 0 means 1)
//   busy, done                measurement in progress / one-cycle result-valid pulse
//   fx_cnt, fs_cnt, ch_out    periods counted, reference cycles counted, channel of the results
//   timeout_err, overflow_err how the last measurement ended
module freq_meter_mc #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 32,
    parameter int EDGE_W  = 16,
    parameter int TIMEOUT = 100_000_000,
    parameter int CLK_FS  = 100_000_000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [EDGE_W-1:0] gate_edges,
    output logic              busy,
    output logic              done,
    output logic [EDGE_W-1:0] fx_cnt,
    output logic [CNT_W-1:0]  fs_cnt,
    output logic [CH_W-1:0]   ch_out,
    output logic              timeout_err,
    output logic              overflow_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int CH_N  = 1 << CH_W;
    // A misconfigured instance rejects every request as an invalid channel
    // instead of producing meaningless counts.
    localparam bit CFG_OK = (NUM_CH >= 1) && (NUM_CH <= 16) && (CH_N >= NUM_CH) &&
                            (TIMEOUT >= 1) && (CLK_FS >= 1);

    typedef enum logic [1:0] {IDLE, ARM, GATE, FIN} state_t;

    state_t state, state_d;

    logic [NUM_CH-1:0] s1, s2, s3;
    logic [NUM_CH-1:0] rise;
    logic [CH_N-1:0]   rise_ext;

    logic [CH_W-1:0]   ch_q, ch_d;
    logic [EDGE_W-1:0] n_q, n_d;
    logic [EDGE_W-1:0] fx_r, fx_d;
    logic [CNT_W-1:0]  fs_r, fs_d;
    logic [TMO_W-1:0]  tmo, tmo_d;
    logic [EDGE_W-1:0] res_fx, res_fx_d;
    logic [CNT_W-1:0]  res_fs, res_fs_d;
    logic              res_tmo, res_tmo_d;
    logic              res_ovf, res_ovf_d;

    logic ch_ok, ch_rise, fs_full, tmo_hit, close_hit;

    // Two synchroniser flops plus one history flop per channel.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Pad to a power of two so any ch_q value indexes a defined bit.
    always_comb begin
        rise_ext             = '0;
        rise_ext[NUM_CH-1:0] = rise;
    end

    always_comb begin
        ch_ok     = CFG_OK && ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));
        ch_rise   = rise_ext[ch_q];
        fs_full   = &fs_r;
        tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
        close_hit = ch_rise && ((fx_r + EDGE_W'(1)) == n_q);

        state_d   = state;
        ch_d      = ch_q;
        n_d       = n_q;
        fx_d      = fx_r;
        fs_d      = fs_r;
        tmo_d     = tmo;
        res_fx_d  = res_fx;
        res_fs_d  = res_fs;
        res_tmo_d = res_tmo;
        res_ovf_d = res_ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    ch_d = ch_sel;
                    if (ch_ok) begin
                        n_d     = (gate_edges == '0) ? EDGE_W'(1) : gate_edges;
                        tmo_d   = '0;
                        fs_d    = '0;
                        fx_d    = '0;
                        state_d = ARM;
                    end else begin
                        res_fx_d  = '0;
                        res_fs_d  = '0;
                        res_tmo_d = 1'b1;
                        res_ovf_d = 1'b0;
                        state_d   = FIN;
                    end
                end
            end
            ARM: begin
                // An opening edge beats a timeout expiring in the same cycle.
                if (ch_rise) begin
                    fs_d    = '0;
                    fx_d    = '0;
                    tmo_d   = '0;
                    state_d = GATE;
                end else if (tmo_hit) begin
                    res_fx_d  = fx_r;
                    res_fs_d  = fs_r;
                    res_tmo_d = 1'b1;
                    res_ovf_d = 1'b0;
                    state_d   = FIN;
                end else begin
                    tmo_d = tmo + TMO_W'(1);
                end
            end
            GATE: begin
                if (close_hit) begin
                    res_fx_d  = n_q;
                    res_fs_d  = fs_r + CNT_W'(1);
                    res_tmo_d = 1'b0;
                    res_ovf_d = 1'b0;
                    state_d   = FIN;
                end else if (fs_full) begin
                    res_fx_d  = fx_r;
                    res_fs_d  = '1;
                    res_tmo_d = 1'b0;
                    res_ovf_d = 1'b1;
                    state_d   = FIN;
                end else if (!ch_rise && tmo_hit) begin
                    res_fx_d  = fx_r;
                    res_fs_d  = fs_r;
                    res_tmo_d = 1'b1;
                    res_ovf_d = 1'b0;
                    state_d   = FIN;
                end else begin
                    fs_d = fs_r + CNT_W'(1);
                    if (ch_rise) begin
                        fx_d  = fx_r + EDGE_W'(1);
                        tmo_d = '0;
                    end else begin
                        tmo_d = tmo + TMO_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch_q    <= '0;
            n_q     <= '0;
            fx_r    <= '0;
            fs_r    <= '0;
            tmo     <= '0;
            res_fx  <= '0;
            res_fs  <= '0;
            res_tmo <= 1'b0;
            res_ovf <= 1'b0;
        end else begin
            state   <= state_d;
            ch_q    <= ch_d;
            n_q     <= n_d;
            fx_r    <= fx_d;
            fs_r    <= fs_d;
            tmo     <= tmo_d;
            res_fx  <= res_fx_d;
            res_fs  <= res_fs_d;
            res_tmo <= res_tmo_d;
            res_ovf <= res_ovf_d;
        end
    end

    // Results are published one cycle after FIN so they line up with done;
    // busy stays high through that done cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            fx_cnt       <= '0;
            fs_cnt       <= '0;
            ch_out       <= '0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            busy <= (state_d != IDLE) || (state == FIN);
            done <= (state == FIN);
            if (state == FIN) begin
                fx_cnt       <= res_fx;
                fs_cnt       <= res_fs;
                ch_out       <= ch_q;
                timeout_err  <= res_tmo;
                overflow_err <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Purpose : bench for freq_meter_mc; trace-based reference model plus directed literal checks.
// Latency : outputs compared every cycle, 6 time units after the rising edge.
// Backpr. : n/a; the bench predicts which start requests the DUT accepts.
module tb_freq_meter_mc;

    localparam int     NCH       = 4;
    localparam int     TMO       = 50;
    localparam int     MAXC      = 20000;
    localparam longint CMAX_MAIN = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        int t;
        int ch;
        int n;
    } meas_t;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst_n;
    logic [3:0]  sig;
    logic        start;
    logic [2:0]  ch_sel;
    logic [15:0] gate_edges;
    logic        busy, done;
    logic [15:0] fx_cnt;
    logic [31:0] fs_cnt;
    logic [2:0]  ch_out;
    logic        timeout_err, overflow_err;

    logic        start_o;
    logic [1:0]  ch_sel_o;
    logic [15:0] gate_o;
    logic        busy_o, done_o;
    logic [15:0] fx_o;
    logic [7:0]  fs_o;
    logic [1:0]  ch_o;
    logic        te_o, oe_o;

    freq_meter_mc #(.NUM_CH(4), .CH_W(3), .CNT_W(32), .EDGE_W(16), .TIMEOUT(TMO), .CLK_FS(100_000_000)) u_dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sig_in(sig), .start(start), .ch_sel(ch_sel),
        .gate_edges(gate_edges), .busy(busy), .done(done), .fx_cnt(fx_cnt), .fs_cnt(fs_cnt),
        .ch_out(ch_out), .timeout_err(timeout_err), .overflow_err(overflow_err)
    );

    freq_meter_mc #(.NUM_CH(4), .CH_W(2), .CNT_W(8), .EDGE_W(16), .TIMEOUT(TMO), .CLK_FS(100_000_000)) u_ovf (
        .sys_clk(sys_clk), .rst_n(rst_n), .sig_in(sig), .start(start_o), .ch_sel(ch_sel_o),
        .gate_edges(gate_o), .busy(busy_o), .done(done_o), .fx_cnt(fx_o), .fs_cnt(fs_o),
        .ch_out(ch_o), .timeout_err(te_o), .overflow_err(oe_o)
    );

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // hist[k] = input value sampled by the first synchroniser flop at the end of cycle k
    bit [3:0] hist [MAXC];
    int per [NCH];
    int hi  [NCH];
    int ph  [NCH];
    bit hold[NCH];
    meas_t mq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A rise is seen by the measurement logic two cycles after the first high sample.
    function automatic bit rise_at(input int q, input int ch);
        bit a, b;
        a = (q >= 2 && q - 2 < MAXC) ? hist[q-2][ch] : 1'b0;
        b = (q >= 3 && q - 3 < MAXC) ? hist[q-3][ch] : 1'b0;
        return a & ~b;
    endfunction

    // Cycle in which the measurement decides its outcome (done follows 2 cycles later),
    // or -1 if no outcome is decided by cycle 'limit'.
    function automatic int model_end(input meas_t m, input int limit, input longint cmax,
                                     output longint fx, output longint fs, output bit te, output bit oe);
        int last, open, edges, n_eff;
        fx = 0; fs = 0; te = 0; oe = 0;
        if (m.ch >= NCH) begin
            te = 1;
            return m.t;
        end
        n_eff = (m.n == 0) ? 1 : m.n;
        last  = m.t;
        open  = -1;
        edges = 0;
        for (int g = m.t + 1; g <= limit; g++) begin
            bit r;
            r = rise_at(g, m.ch);
            if (open < 0) begin
                if (r) begin
                    open = g;
                    last = g;
                end else if (g - last == TMO) begin
                    te = 1;
                    return g;
                end
            end else begin
                if (r && edges + 1 == n_eff) begin
                    fx = n_eff;
                    fs = longint'(g - open) & cmax;
                    return g;
                end
                if (longint'(g - open - 1) == cmax) begin
                    oe = 1; fs = cmax; fx = edges;
                    return g;
                end
                if (r) begin
                    edges++;
                    last = g;
                end else if (g - last == TMO) begin
                    te = 1; fx = edges; fs = g - open - 1;
                    return g;
                end
            end
        end
        return -1;
    endfunction

    function automatic bit model_idle(input int p);
        longint a, b;
        bit c, d;
        int e;
        if (mq.size() == 0) return 1'b1;
        e = model_end(mq[mq.size()-1], p - 2, CMAX_MAIN, a, b, c, d);
        return (e >= 0) && (e + 2 <= p);
    endfunction

    // Signal generator: periodic square waves, optionally held low.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            for (int i = 0; i < NCH; i++) begin
                if (!hold[i]) ph[i] = (ph[i] + 1) % per[i];
                sig[i] = hold[i] ? 1'b0 : (ph[i] < hi[i]);
            end
            if (cyc < MAXC) hist[cyc] = rst_n ? sig : 4'b0;
        end
    end

    // Compare process: DUT vs reference model every cycle.
    initial begin
        longint mfx, mfs, efx, efs;
        bit mte, moe, ete, eoe, edone, ebusy;
        int e, ech;
        efx = 0; efs = 0; ete = 0; eoe = 0; ech = 0;
        forever begin
            @(posedge sys_clk);
            #6;
            edone = 0;
            ebusy = 0;
            if (!rst_n) begin
                efx = 0; efs = 0; ete = 0; eoe = 0; ech = 0;
            end else if (mq.size() > 0) begin
                e = model_end(mq[0], cyc - 2, CMAX_MAIN, mfx, mfs, mte, moe);
                if (cyc >= mq[0].t + 1 && (e < 0 || cyc <= e + 2)) ebusy = 1;
                if (e >= 0 && e + 2 == cyc) begin
                    edone = 1;
                    efx = mfx; efs = mfs; ete = mte; eoe = moe; ech = mq[0].ch;
                end
                if (e >= 0 && e + 2 <= cyc) void'(mq.pop_front());
            end
            chk("done", done, edone);
            chk("busy", busy, ebusy);
            chk("fx_cnt", fx_cnt, efx);
            chk("fs_cnt", fs_cnt, efs);
            chk("ch_out", ch_out, ech);
            chk("timeout_err", timeout_err, ete);
            chk("overflow_err", overflow_err, eoe);
        end
    end

    task automatic next_cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic try_start(input int ch, input int n);
        start      = 1'b1;
        ch_sel     = 3'(ch);
        gate_edges = 16'(n);
        if (model_idle(cyc)) mq.push_back('{t: cyc, ch: ch, n: n});
        next_cyc();
        start = 1'b0;
    endtask

    task automatic wait_main(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge sys_clk);
            #7;
            if (done) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        int t0;
        bit ok;
        rst_n = 1'b0; start = 1'b0; ch_sel = '0; gate_edges = '0;
        start_o = 1'b0; ch_sel_o = '0; gate_o = '0; sig = '0;
        per  = '{10, 12, 7, 20};
        hi   = '{5, 6, 3, 10};
        hold = '{0, 0, 0, 0};
        repeat (3) next_cyc();
        chk("reset_busy", busy, 0);
        chk("reset_fs", fs_cnt, 0);
        chk("reset_te", timeout_err, 0);
        chk("reset_ovf_fs", fs_o, 0);
        rst_n = 1'b1;
        repeat (30) next_cyc();

        // ch0, period 10, 100 periods
        try_start(0, 100);
        wait_main(1200, "t1_done_seen");
        chk("t1_fx", fx_cnt, 100);
        chk("t1_fs", fs_cnt, 1000);
        chk("t1_ch", ch_out, 0);
        chk("t1_err", {timeout_err, overflow_err}, 0);
        next_cyc();

        // ch2, period 7, gate_edges 0 behaves as 1
        try_start(2, 0);
        wait_main(100, "t2_done_seen");
        chk("t2_fx", fx_cnt, 1);
        chk("t2_fs", fs_cnt, 7);
        chk("t2_ch", ch_out, 2);
        next_cyc();

        // ch1 held low: timeout 52 cycles after accept
        hold[1] = 1;
        repeat (10) next_cyc();
        t0 = cyc;
        try_start(1, 5);
        wait_main(100, "t3_done_seen");
        chk("t3_latency", cyc - t0, 52);
        chk("t3_te", timeout_err, 1);
        chk("t3_fx", fx_cnt, 0);
        chk("t3_fs", fs_cnt, 0);
        hold[1] = 0;
        next_cyc();
        try_start(0, 3);
        wait_main(100, "t3b_done_seen");
        chk("t3b_te_cleared", timeout_err, 0);
        chk("t3b_fs", fs_cnt, 30);

        // start while busy is ignored; then an invalid channel
        next_cyc();
        try_start(0, 5);
        repeat (2) next_cyc();
        try_start(5, 1);
        wait_main(200, "t4_done_seen");
        chk("t4_fx", fx_cnt, 5);
        chk("t4_fs", fs_cnt, 50);
        chk("t4_ch", ch_out, 0);
        chk("t4_te", timeout_err, 0);
        next_cyc();
        t0 = cyc;
        try_start(5, 1);
        wait_main(10, "t4b_done_seen");
        chk("t4b_latency", cyc - t0, 2);
        chk("t4b_te", timeout_err, 1);
        chk("t4b_ch", ch_out, 5);
        chk("t4b_fs", fs_cnt, 0);

        // reset in the middle of a gate
        next_cyc();
        try_start(0, 50);
        repeat (100) next_cyc();
        rst_n = 1'b0;
        mq.delete();
        #6;
        chk("t5_busy", busy, 0);
        chk("t5_te", timeout_err, 0);
        chk("t5_ch", ch_out, 0);
        repeat (3) next_cyc();
        rst_n = 1'b1;
        repeat (5) next_cyc();
        try_start(0, 10);
        wait_main(200, "t5_done_seen");
        chk("t5_fs", fs_cnt, 100);
        chk("t5_fx", fx_cnt, 10);
        next_cyc();

        // 8-bit reference counter saturates: period 20, 20 periods
        start_o = 1'b1; ch_sel_o = 2'd3; gate_o = 16'd20;
        next_cyc();
        start_o = 1'b0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk);
            #7;
            if (done_o) begin
                ok = 1;
                break;
            end
        end
        chk("t6_done_seen", ok, 1);
        chk("t6_fs", fs_o, 255);
        chk("t6_fx", fx_o, 12);
        chk("t6_ovf", oe_o, 1);
        chk("t6_te", te_o, 0);
        chk("t6_ch", ch_o, 3);
        next_cyc();

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                int c;
                c = $urandom_range(0, NCH - 1);
                per[c]  = $urandom_range(4, 20);
                hi[c]   = $urandom_range(2, per[c] - 2);
                hold[c] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                int c, n;
                c = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
                n = $urandom_range(0, 6);
                try_start(c, n);
            end else begin
                next_cyc();
            end
        end
        repeat (400) next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freq_meter_mc.md
# freq_meter_mc

Multi-channel, parametrised equal-precision frequency meter in the single `sys_clk` domain. Each of `NUM_CH` asynchronous test signals is synchronised and edge-detected. On `start`, one selected channel is measured over a gate of exactly `gate_edges` signal periods, counting reference cycles across that gate, so relative error is set by `sys_clk` and not by the test signal. It sits between the signal-conditioning inputs and the frequency-computation/display logic, which forms `f = CLK_FS * fx_cnt / fs_cnt`.

## Interface
- `NUM_CH`, 4: number of test-signal inputs (1..16)
- `CH_W`, 2: width of `ch_sel`; must satisfy 2^CH_W ≥ NUM_CH
- `CNT_W`, 32: width of reference counter `fs_cnt`
- `EDGE_W`, 16: width of `gate_edges` / `fx_cnt`
- `TIMEOUT`, 100_000_000: max `sys_clk` cycles allowed between consecutive qualifying edges (ARM or GATE)
- `CLK_FS`, 100_000_000: reference frequency in Hz; informational, passed to downstream math
- `sys_clk` input 1: reference clock, all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `sig_in` input NUM_CH: asynchronous test signals
- `start` input 1: one-cycle request; ignored while `busy`=1
- `ch_sel` input CH_W: channel to measure, sampled with `start`
- `gate_edges` input EDGE_W: gate length in signal periods, sampled with `start`; 0 treated as 1
- `busy` output 1: high from the cycle after accepted `start` until the `done` cycle, inclusive
- `done` output 1: one-cycle pulse, results valid from this cycle
- `fx_cnt` output EDGE_W: signal periods inside the gate
- `fs_cnt` output CNT_W: `sys_clk` cycles inside the gate
- `ch_out` output CH_W: channel the results belong to
- `timeout_err` output 1: last measurement ended by timeout or invalid channel
- `overflow_err` output 1: last measurement ended by `fs_cnt` saturation

## Operation
- Per channel: 2-flop synchroniser plus a third flop. `rise[i] = s2 & ~s3`. Channel high and low times must each be ≥ 2 `sys_clk` periods.
- FSM states: IDLE, ARM, GATE, FIN.
- IDLE:
  - On `start` with `ch_sel` < NUM_CH: latch channel and N = max(`gate_edges`, 1), clear timeout counter, go to ARM.
  - On `start` with `ch_sel` ≥ NUM_CH: go to FIN with `timeout_err`=1 and counts 0.
- ARM: wait for `rise` on the latched channel (gate opens).
  - On rise: fs_r ← 0, fx_r ← 0, go to GATE.
- GATE: every cycle fs_r ← fs_r+1. On rise, fx_r ← fx_r+1.
  - Rise with fx_r+1 == N: `fs_cnt` ← fs_r+1, `fx_cnt` ← N, go to FIN. The close edge of one measurement is not reused as an open edge.
- Timeout: counter runs in ARM/GATE, clears on every rise. Reaching TIMEOUT → FIN with `timeout_err`=1, `fx_cnt` ← fx_r, `fs_cnt` ← fs_r.
- Overflow: if fs_r+1 would wrap → `fs_cnt` ← all-ones, `fx_cnt` ← fx_r, `overflow_err`=1, go to FIN.
- Priority within a cycle: close edge > overflow > timeout.
- FIN: assert `done` for one cycle, update `ch_out`, return to IDLE. Error flags are rewritten (set or cleared) on every `done`.
- Results and flags hold until the next `done`.
- A `start` in the FIN cycle is ignored. A `start` in the first IDLE cycle after FIN is accepted.

## Timing
- Reset values: `busy`, `done`, `timeout_err`, `overflow_err` = 0; `fx_cnt`, `fs_cnt`, `ch_out` = 0; FSM = IDLE; synchroniser flops = 0.
- Reset asserted mid-measurement aborts immediately: no `done` pulse, all outputs return to reset values.
- `start` accepted in cycle t → `busy`=1 at t+1.
- Input rise to internal `rise` pulse: 3 cycles (2 sync + 1 detect), for both the open and close edges, so it cancels in `fs_cnt`.
- Close rise seen in cycle c (state GATE) → `fs_cnt`/`fx_cnt` valid and `done`=1 at c+2. `busy` falls at c+3.
- Periodic input of period P cycles, N edges: `fs_cnt` = N·P exactly. For jittered or asynchronous inputs, ±1 count.
- Invalid channel: `done` two cycles after `start`.

## Test plan
- Ch 0 period 10 cycles, N=100 → `done`, `fx_cnt`=100, `fs_cnt`=1000, `ch_out`=0, no errors.
- Ch 2 period 7, N=0 → `fx_cnt`=1, `fs_cnt`=7; other channels toggling do not affect the result.
- Ch 1 held low, TIMEOUT=50 → `done` 52 cycles after accept, `timeout_err`=1, `fx_cnt`=0, `fs_cnt`=0. A following good measurement clears `timeout_err`.
- CNT_W=8, period 20, N=20 → `overflow_err`=1, `fs_cnt`=255.
- Second `start` while `busy`; `ch_sel`=5 with NUM_CH=4 → first ignored, second gives `timeout_err`=1.
- `rst_n` pulsed low mid-GATE → outputs 0 immediately, no `done`. A new `start` measures correctly.
